// File: rtl/uart_wb_regs.sv
// rtl/uart_wb_regs.sv - 16550-style UART register file behind a Wishbone slave port
module uart_wb_regs #(
    parameter int          RX_DEPTH = 4,
    parameter logic [15:0] DIV_RST  = 16'h003C
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_stb,
    input  logic        wb_we,
    input  logic [2:0]  wb_addr,
    input  logic [7:0]  wb_data_i,
    output logic [7:0]  wb_data_o,
    output logic        wb_ack,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic        tx_busy,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [15:0] divisor,
    output logic [7:0]  lc
);

    localparam int AW = $clog2(RX_DEPTH);
    localparam int CW = AW + 1;

    logic          ack_q, ack_d;
    logic [7:0]    rdata_q, rdata_d;
    logic [7:0]    lc_q, lc_d;
    logic [15:0]   dl_q, dl_d;
    logic [7:0]    ie_q, ie_d;
    logic [7:0]    mc_q, mc_d;
    logic [7:0]    sr_q, sr_d;
    logic [7:0]    thr_q, thr_d;
    logic          txv_q, txv_d;
    logic          oe_q, oe_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    mem [RX_DEPTH];

    logic       access, dlab, rd, wr, rb_rd, tr_wr, ls_rd;
    logic       empty, full, pop, push, overrun, handoff, thr_load;
    logic [7:0] ls, rd_mux;

    assign access   = wb_stb && !ack_q;
    assign dlab     = lc_q[7];
    assign rd       = access && !wb_we;
    assign wr       = access && wb_we;
    assign rb_rd    = rd && (wb_addr == 3'd0) && !dlab;
    assign tr_wr    = wr && (wb_addr == 3'd0) && !dlab;
    assign ls_rd    = rd && (wb_addr == 3'd5);
    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CW'(RX_DEPTH));
    assign pop      = rb_rd && !empty;
    // A pop at the same edge frees the slot, so a full FIFO can still accept
    assign push     = rx_valid && (!full || pop);
    assign overrun  = rx_valid && full && !pop;
    assign handoff  = txv_q && tx_ready;
    assign thr_load = tr_wr && (!txv_q || handoff);

    assign ls = {1'b0, !txv_q && !tx_busy, !txv_q, 3'b000, oe_q, !empty};

    always_comb begin
        rd_mux = 8'h00;
        case (wb_addr)
            3'd0:    rd_mux = dlab ? dl_q[7:0] : (empty ? 8'h00 : mem[rptr_q]);
            3'd1:    rd_mux = dlab ? dl_q[15:8] : ie_q;
            3'd2:    rd_mux = 8'hC1;
            3'd3:    rd_mux = lc_q;
            3'd4:    rd_mux = mc_q;
            3'd5:    rd_mux = ls;
            3'd6:    rd_mux = 8'h00;
            default: rd_mux = sr_q;
        endcase
    end

    always_comb begin
        ack_d   = access;
        rdata_d = rd ? rd_mux : rdata_q;
        lc_d    = lc_q;
        dl_d    = dl_q;
        ie_d    = ie_q;
        mc_d    = mc_q;
        sr_d    = sr_q;
        if (wr) begin
            case (wb_addr)
                3'd0:    if (dlab) dl_d[7:0] = wb_data_i;
                3'd1:    if (dlab) dl_d[15:8] = wb_data_i; else ie_d = wb_data_i;
                3'd3:    lc_d = wb_data_i;
                3'd4:    mc_d = wb_data_i;
                3'd7:    sr_d = wb_data_i;
                default: ;
            endcase
        end
        thr_d = thr_load ? wb_data_i : thr_q;
        txv_d = thr_load ? 1'b1 : (handoff ? 1'b0 : txv_q);
        oe_d  = overrun ? 1'b1 : (ls_rd ? 1'b0 : oe_q);
        wptr_d = push ? wptr_q + AW'(1) : wptr_q;
        rptr_d = pop ? rptr_q + AW'(1) : rptr_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q   <= 1'b0;
            rdata_q <= 8'h00;
            lc_q    <= 8'h00;
            dl_q    <= DIV_RST;
            ie_q    <= 8'h00;
            mc_q    <= 8'h00;
            sr_q    <= 8'h00;
            thr_q   <= 8'h00;
            txv_q   <= 1'b0;
            oe_q    <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            lc_q    <= lc_d;
            dl_q    <= dl_d;
            ie_q    <= ie_d;
            mc_q    <= mc_d;
            sr_q    <= sr_d;
            thr_q   <= thr_d;
            txv_q   <= txv_d;
            oe_q    <= oe_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage needs no reset: the pointers and count alone define what is valid
    always_ff @(posedge clk) begin
        if (push) mem[wptr_q] <= rx_data;
    end

    assign wb_ack    = ack_q;
    assign wb_data_o = rdata_q;
    assign tx_data   = thr_q;
    assign tx_valid  = txv_q;
    assign divisor   = dl_q;
    assign lc        = lc_q;

endmodule

// File: doc/uart_wb_regs.md
Name: uart_wb_regs

Overview:
- Wishbone slave register file presenting a 16550-style 8-bit UART register map to a Wishbone master.
- Sits between the UART access state machine (the Wishbone master) and the byte-level serializer/deserializer and baud generator.
- Holds LC, the divisor latch, IE, MC and SR registers, plus a single-entry transmit holding register (THR) and a small RX FIFO.
- Derives LS status bits from TX/RX state; all accesses complete with a one-cycle registered ack.

Parameters:
- RX_DEPTH, 4, RX FIFO entries (power of two, 2..16).
- DIV_RST, 16'h003C, divisor latch reset value {DL2,DL1}.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- wb_stb  in  1  access strobe from master.
- wb_we  in  1  1 = write, 0 = read.
- wb_addr  in  3  register address.
- wb_data_i  in  8  write data from master.
- wb_data_o  out  8  read data to master.
- wb_ack  out  1  access-complete pulse.
- tx_data  out  8  THR contents to serializer.
- tx_valid  out  1  THR full.
- tx_ready  in  1  serializer accepts tx_data this cycle.
- tx_busy  in  1  serializer shifting a character.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle pulse: rx_data valid.
- divisor  out  16  {DL2,DL1} to baud generator.
- lc  out  8  line-control register.

Behaviour:
- Reset values:
  - wb_ack=0, wb_data_o=8'h00, tx_valid=0, tx_data=8'h00.
  - LC=8'h00, divisor=DIV_RST, IE=MC=SR=8'h00.
  - RX FIFO empty; OE=0.
- Access timing:
  - Access accepted on any posedge where wb_stb=1 and wb_ack=0.
  - At that edge: wb_ack goes to 1 for exactly one cycle; write side-effects and pop/clear side-effects take effect; wb_data_o is loaded with read data.
  - If wb_stb is still 1 with wb_ack=1, no access occurs that cycle. A held strobe therefore produces an ack every second cycle, each ack a fresh access.
  - wb_data_o holds its value between acks.
- DLAB = LC[7]. Address map:
  - 0: read RB (DLAB=0) / write TR (DLAB=0); DL1 read/write when DLAB=1.
  - 1: IE read/write (DLAB=0); DL2 read/write when DLAB=1.
  - 2: read II=8'hC1; writes ignored.
  - 3: LC read/write.
  - 4: MC read/write.
  - 5: read LS; writes ignored.
  - 6: read MS=8'h00; writes ignored.
  - 7: SR scratch read/write.
- LS bits:
  - [0] DR = RX FIFO not empty.
  - [1] OE overrun flag.
  - [5] THRE = !tx_valid.
  - [6] TEMT = !tx_valid && !tx_busy.
  - All other bits 0.
  - LS is sampled at the access edge, before that edge's updates.
- RB read:
  - Non-empty FIFO: returns head and pops it.
  - Empty FIFO: returns 8'h00, no pop, no error.
- RX push (rx_valid=1):
  - FIFO not full: push rx_data.
  - FIFO full: drop byte and set OE.
  - Full, with an RB pop at the same edge: the pop and push both occur; no overrun.
- OE clears on an LS read. If an overrun occurs at the same edge as the LS read, OE stays 1.
- TR write:
  - THR empty: load tx_data, set tx_valid.
  - THR full and no handoff this cycle: write dropped; ack still given.
- TX handoff:
  - tx_valid && tx_ready transfers the byte; tx_valid clears next edge.
  - Handoff and TR write at the same edge: new byte loaded; tx_valid stays 1.
- FIFO pointers are log2(RX_DEPTH) bits and wrap modulo RX_DEPTH. Occupancy counter is log2(RX_DEPTH)+1 bits.
- DLAB change takes effect on the access after the LC write.
- divisor and lc update at the write's ack edge.
- Reset asserted mid-access: all state returns to reset values immediately; any pending ack is lost; the FIFO is flushed.

Test Plan:
- Reset then read LS → ack after 1 cycle, data 8'h60; read LC → 8'h00; divisor=16'h003C.
- Init sequence: write LC=80, DL2=00, DL1=3C, LC=03 → divisor=16'h003C, lc=8'h03; reading addr 0 with DLAB=0 returns RB, not 3C.
- TX: write TR=A5 with tx_ready=0 → tx_valid=1, LS=8'h00 (tx_busy=1); write TR=5A → dropped, tx_data stays A5; tx_ready pulse → THRE=1.
- RX: push 11,22,33,44,55 with RX_DEPTH=4 → LS=8'h03; RB reads return 11,22,33,44 then 00; next LS read → 8'h60.
- Simultaneous: FIFO full, RB read and rx_valid on the same edge → no OE; FIFO holds 4 entries with the new byte at the tail.
- Held strobe polling LS for 6 cycles → 3 ack pulses at cycles 1,3,5; assert rst during an ack → wb_ack=0 immediately, FIFO empty.
